// File: rtl/hybrid_ctrl_if.sv
// Bundles the hybrid_ctrl handshake and datapath-facing signals.
// slave is the controller side; master is the operand source, result sink and hybrid unit.
interface hybrid_ctrl_if #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 8,
  parameter int W_ACC = 16
);
  logic             start;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_data;
  logic [W_IN-1:0]  hyb_in;
  logic             hyb_sign;
  logic [W_OUT-1:0] hyb_abs;
  logic [W_ACC-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;

  modport slave (
    input  start, in_valid, in_data, hyb_sign, hyb_abs, out_ready,
    output busy, in_ready, hyb_in, acc_out, out_valid, ovf
  );

  modport master (
    output start, in_valid, in_data, hyb_sign, hyb_abs, out_ready,
    input  busy, in_ready, hyb_in, acc_out, out_valid, ovf
  );
endinterface

// File: rtl/hybrid_ctrl.sv
// Issues a LEN-operand vector to the hybrid sign/magnitude unit and accumulates its results.
// Define HYBRID_CTRL_SAT_EN for a saturating accumulator with a sticky ovf flag.
module hybrid_ctrl #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 8,
  parameter int LEN   = 16,
  parameter int W_ACC = 16
) (
  input  logic         clock,
  input  logic         resetn,
  hybrid_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] acc_cnt;
  logic             v1;
  logic             v2;
  logic [W_IN-1:0]  hyb_in_r;
  logic [W_ACC-1:0] acc;
  logic [W_ACC-1:0] acc_next;
  logic             accept;

  assign bus.in_ready  = (state == RUN) && (issue_cnt < LEN_C);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.acc_out   = acc;
  assign bus.hyb_in    = hyb_in_r;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef HYBRID_CTRL_SAT_EN
  // One extra bit catches a single step leaving the signed range; clamp toward that side.
  logic [W_ACC:0] acc_wide;
  logic [W_ACC:0] add_wide;
  logic [W_ACC:0] sum_wide;
  logic           ovf_hit;
  logic           ovf_r;

  always_comb begin
    acc_wide = {acc[W_ACC-1], acc};
    add_wide = {{(W_ACC + 1 - W_OUT){1'b0}}, bus.hyb_abs};
    sum_wide = bus.hyb_sign ? (acc_wide - add_wide) : (acc_wide + add_wide);
    ovf_hit  = (sum_wide[W_ACC] != sum_wide[W_ACC-1]);
    acc_next = sum_wide[W_ACC-1:0];
    if (ovf_hit) begin
      acc_next = sum_wide[W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}} : {1'b0, {(W_ACC-1){1'b1}}};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      ovf_r <= 1'b0;
    end else if (v2 && ovf_hit) begin
      ovf_r <= 1'b1;
    end
  end

  assign bus.ovf = ovf_r;
`else
  logic [W_ACC-1:0] addend;

  always_comb begin
    addend   = {{(W_ACC - W_OUT){1'b0}}, bus.hyb_abs};
    acc_next = bus.hyb_sign ? (acc - addend) : (acc + addend);
  end

  assign bus.ovf = 1'b0;
`endif

  // v1/v2 follow each accepted operand through hyb_in and the unit's output register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      hyb_in_r  <= '0;
      acc       <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (accept) begin
        hyb_in_r  <= bus.in_data;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (v2) begin
        acc     <= acc_next;
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RUN;
            acc       <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
          end
        end
        RUN: begin
          if (accept && issue_cnt == LAST_C) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (v2 && acc_cnt == LAST_C) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hybrid_ctrl.sv
// Bench for hybrid_ctrl: DUT A (LEN=4, W_ACC=16) and DUT B (LEN=16, W_ACC=10), each fed by a
// behavioural hybrid unit; table vectors, hand sequences and random vectors against a sum model.
module tb_hybrid_ctrl;

`ifdef HYBRID_CTRL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0][7:0] ops;
    int               n;
    int               gap;
    bit               use_b;
    bit               mid_start;
    int               hold;
    int               exp_acc;
    bit               exp_ovf;
  } vec_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic       use_b = 1'b0;
  logic       start_d = 1'b0;
  logic       valid_d = 1'b0;
  logic       ready_d = 1'b0;
  logic [7:0] data_d = 8'd0;

  hybrid_ctrl_if #(.W_IN(8), .W_OUT(8), .W_ACC(16)) bus_a ();
  hybrid_ctrl_if #(.W_IN(8), .W_OUT(8), .W_ACC(10)) bus_b ();

  hybrid_ctrl #(.W_IN(8), .W_OUT(8), .LEN(4), .W_ACC(16)) dut_a (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus_a)
  );

  hybrid_ctrl #(.W_IN(8), .W_OUT(8), .LEN(16), .W_ACC(10)) dut_b (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus_b)
  );

  assign bus_a.start     = start_d & ~use_b;
  assign bus_a.in_valid  = valid_d & ~use_b;
  assign bus_a.in_data   = data_d;
  assign bus_a.out_ready = ready_d & ~use_b;
  assign bus_b.start     = start_d & use_b;
  assign bus_b.in_valid  = valid_d & use_b;
  assign bus_b.in_data   = data_d;
  assign bus_b.out_ready = ready_d & use_b;

  // Hybrid unit stand-ins: sign and magnitude of hyb_in, registered one cycle.
  logic       a_sign = 1'b0;
  logic [7:0] a_abs = 8'd0;
  logic       b_sign = 1'b0;
  logic [7:0] b_abs = 8'd0;
  always @(posedge clock) begin
    a_sign <= bus_a.hyb_in[7];
    a_abs  <= bus_a.hyb_in[7] ? 8'(-bus_a.hyb_in) : bus_a.hyb_in;
    b_sign <= bus_b.hyb_in[7];
    b_abs  <= bus_b.hyb_in[7] ? 8'(-bus_b.hyb_in) : bus_b.hyb_in;
  end
  assign bus_a.hyb_sign = a_sign;
  assign bus_a.hyb_abs  = a_abs;
  assign bus_b.hyb_sign = b_sign;
  assign bus_b.hyb_abs  = b_abs;

  wire              cur_busy      = use_b ? bus_b.busy : bus_a.busy;
  wire              cur_in_ready  = use_b ? bus_b.in_ready : bus_a.in_ready;
  wire              cur_out_valid = use_b ? bus_b.out_valid : bus_a.out_valid;
  wire              cur_ovf       = use_b ? bus_b.ovf : bus_a.ovf;
  wire [7:0]        cur_hyb_in    = use_b ? bus_b.hyb_in : bus_a.hyb_in;
  wire signed [31:0] cur_acc      = use_b ? {{22{bus_b.acc_out[9]}}, bus_b.acc_out}
                                          : {{16{bus_a.acc_out[15]}}, bus_a.acc_out};

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sum of operands, clamped every step when saturating, otherwise wrapped at the end.
  function automatic int modelSum(input logic [15:0][7:0] ops, input int n, input int wacc,
                                  output bit ovf);
    longint acc = 0;
    longint hi = (64'sd1 <<< (wacc - 1)) - 1;
    longint lo = -(64'sd1 <<< (wacc - 1));
    longint span = 64'sd1 <<< wacc;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc += longint'($signed(ops[i]));
      if (SAT && acc > hi) begin acc = hi; ovf = 1'b1; end
      if (SAT && acc < lo) begin acc = lo; ovf = 1'b1; end
    end
    if (!SAT) begin
      acc = ((acc % span) + span) % span;
      if (acc > hi) acc -= span;
    end
    return int'(acc);
  endfunction

  function automatic logic [15:0][7:0] pack4(input int a, input int b, input int c, input int d);
    logic [15:0][7:0] r = '0;
    r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
    return r;
  endfunction

  function automatic logic [15:0][7:0] splat(input int v);
    logic [15:0][7:0] r;
    for (int i = 0; i < 16; i++) r[i] = 8'(v);
    return r;
  endfunction

  // Caller is at a negedge; start is presented for the very next rising edge.
  task automatic applyStimulus(input logic [15:0][7:0] ops, input int n, input int gap,
                               input bit b, input bit mid_start, input int hold,
                               output int act_acc, output bit act_ovf);
    int edges;
    int held_acc;
    use_b   = b;
    start_d = 1'b1;
    @(negedge clock);
    start_d = 1'b0;
    checkOutput("in_ready_after_start", cur_in_ready, 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          valid_d = 1'b0;
          if (mid_start && i == 2 && g == 0) start_d = 1'b1;
          @(negedge clock);
          start_d = 1'b0;
          checkOutput("busy_in_gap", cur_busy, 1);
        end
      end
      valid_d = 1'b1;
      data_d  = ops[i];
      @(negedge clock);
      valid_d = 1'b0;
      checkOutput("hyb_in_loaded", cur_hyb_in, ops[i]);
    end
    checkOutput("in_ready_drain", cur_in_ready, 0);
    edges = 0;
    while (!cur_out_valid && edges < 20) begin
      @(negedge clock);
      edges++;
    end
    checkOutput("out_latency", edges, 2);
    held_acc = cur_acc;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      checkOutput("out_valid_held", cur_out_valid, 1);
      checkOutput("acc_stable", cur_acc, held_acc);
      checkOutput("busy_in_done", cur_busy, 1);
    end
    act_acc = cur_acc;
    act_ovf = cur_ovf;
    ready_d = 1'b1;
    @(negedge clock);
    ready_d = 1'b0;
    checkOutput("idle_after_handshake", cur_busy, 0);
    checkOutput("out_valid_dropped", cur_out_valid, 0);
    checkOutput("acc_retained", cur_acc, act_acc);
  endtask

  vec_t table_v[4];

  initial begin
    int act_acc;
    bit act_ovf;
    int exp_acc;
    bit exp_ovf;
    logic [15:0][7:0] rops;
    int rn;

    table_v[0] = '{pack4(3, -5, 7, -1), 4, 0, 1'b0, 1'b0, 0, 4, 1'b0};
    table_v[1] = '{pack4(3, -5, 7, -1), 4, 2, 1'b0, 1'b1, 5, 4, 1'b0};
    table_v[2] = '{splat(-128), 4, 0, 1'b0, 1'b0, 0, -512, 1'b0};
    table_v[3] = '{splat(127), 16, 0, 1'b1, 1'b0, 0, SAT ? 511 : -16, SAT};

    repeat (3) @(negedge clock);
    checkOutput("rst_busy_a", bus_a.busy, 0);
    checkOutput("rst_in_ready_a", bus_a.in_ready, 0);
    checkOutput("rst_hyb_in_a", bus_a.hyb_in, 0);
    checkOutput("rst_acc_a", bus_a.acc_out, 0);
    checkOutput("rst_out_valid_a", bus_a.out_valid, 0);
    checkOutput("rst_ovf_b", bus_b.ovf, 0);
    checkOutput("rst_busy_b", bus_b.busy, 0);
    resetn = 1'b1;
    @(negedge clock);

    $display("[TB] table vectors");
    for (int t = 0; t < 4; t++) begin
      applyStimulus(table_v[t].ops, table_v[t].n, table_v[t].gap, table_v[t].use_b,
                    table_v[t].mid_start, table_v[t].hold, act_acc, act_ovf);
      checkOutput($sformatf("table%0d_acc", t), act_acc, table_v[t].exp_acc);
      checkOutput($sformatf("table%0d_ovf", t), act_ovf, table_v[t].exp_ovf);
    end

    $display("[TB] reset mid-vector");
    use_b   = 1'b0;
    start_d = 1'b1;
    @(negedge clock);
    start_d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_d = 1'b1;
      data_d  = 8'(i + 5);
      @(negedge clock);
    end
    valid_d = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("busy_before_reset", bus_a.busy, 1);
    resetn = 1'b0;
    #1;
    checkOutput("abort_busy", bus_a.busy, 0);
    checkOutput("abort_in_ready", bus_a.in_ready, 0);
    checkOutput("abort_hyb_in", bus_a.hyb_in, 0);
    checkOutput("abort_acc", bus_a.acc_out, 0);
    checkOutput("abort_out_valid", bus_a.out_valid, 0);
    checkOutput("abort_ovf", bus_a.ovf, 0);
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(pack4(1, 2, 3, 4), 4, 0, 1'b0, 1'b0, 0, act_acc, act_ovf);
    checkOutput("after_reset_acc", act_acc, 10);

    $display("[TB] random vectors");
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) rops[i] = 8'($urandom);
      if (r < 6) begin
        rn = 4;
        exp_acc = modelSum(rops, rn, 16, exp_ovf);
        applyStimulus(rops, rn, int'($urandom_range(0, 2)), 1'b0, 1'b0,
                      int'($urandom_range(0, 3)), act_acc, act_ovf);
      end else begin
        rn = 16;
        exp_acc = modelSum(rops, rn, 10, exp_ovf);
        applyStimulus(rops, rn, int'($urandom_range(0, 1)), 1'b1, 1'b0,
                      int'($urandom_range(0, 3)), act_acc, act_ovf);
      end
      checkOutput($sformatf("rand%0d_acc", r), act_acc, exp_acc);
      checkOutput($sformatf("rand%0d_ovf", r), act_ovf, exp_ovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
